// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: press detection, target generation, scoring and BCD round timer
// for the number-guessing game. Define GUESS_DEBOUNCE_EN to add a press debouncer.
module guess_round_ctrl #(
   parameter int unsigned TICK_DIV    = 5000000,
   parameter logic [7:0]  ROUND_LIMIT = 8'h59,
   parameter int unsigned MAX_TARGET  = 30,
   parameter int unsigned DEB_CYCLES  = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pb,
   input  logic [4:0] sw,
   output logic [4:0] target,
   output logic [6:0] score,
   output logic [7:0] time_bcd,
   output logic [2:0] state,
   output logic       running,
   output logic       hit,
   output logic       game_over,
   output logic       tick
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PLAY  = 3'd1,
      S_PAUSE = 3'd2,
      S_OVER  = 3'd3
   } state_e;

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   function automatic logic [7:0] bcd_inc(input logic [7:0] t);
      if (t[3:0] == 4'd9) return {t[7:4] + 4'd1, 4'd0};
      return {t[7:4], t[3:0] + 4'd1};
   endfunction

   logic pb_s1_q, pb_s2_q;
   logic press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pb_s1_q <= 1'b1;
         pb_s2_q <= 1'b1;
      end else begin
         pb_s1_q <= pb;
         pb_s2_q <= pb_s1_q;
      end
   end

`ifdef GUESS_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);

   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             deb_armed_q, deb_armed_d;
   logic             press_q, press_d;

   // Count consecutive low cycles; one press per low period, re-armed by release.
   always_comb begin
      deb_cnt_d   = deb_cnt_q;
      deb_armed_d = deb_armed_q;
      press_d     = 1'b0;
      if (pb_s2_q) begin
         deb_cnt_d   = '0;
         deb_armed_d = 1'b1;
      end else if (deb_armed_q) begin
         if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            press_d     = 1'b1;
            deb_armed_d = 1'b0;
            deb_cnt_d   = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cnt_q   <= '0;
         deb_armed_q <= 1'b1;
         press_q     <= 1'b0;
      end else begin
         deb_cnt_q   <= deb_cnt_d;
         deb_armed_q <= deb_armed_d;
         press_q     <= press_d;
      end
   end

   assign press = press_q;
`else
   logic pb_prev_q;
   logic deb_unused;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pb_prev_q <= 1'b1;
      else     pb_prev_q <= pb_s2_q;
   end

   assign press      = pb_prev_q & ~pb_s2_q;
   assign deb_unused = DEB_CYCLES[0];
`endif

   state_e           state_q, state_d;
   logic [4:0]       target_q, target_d;
   logic [6:0]       score_q, score_d;
   logic [7:0]       time_q, time_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic             hit_q, hit_d;
   logic             tick_q, tick_d;
   logic             running_q, over_q;
   logic [4:0]       cand;
   logic             wrap;

   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign wrap   = (div_q == DIV_W'(TICK_DIV - 1));

   // Fall back to the next value up when the draw repeats the current target.
   always_comb begin
      cand = 5'((32'(lfsr_q) % MAX_TARGET) + 1);
      if (cand == target_q) cand = 5'((32'(target_q) % MAX_TARGET) + 1);
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      score_d  = score_q;
      time_d   = time_q;
      div_d    = div_q;
      hit_d    = 1'b0;
      tick_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press) begin
               state_d  = S_PLAY;
               target_d = cand;
               score_d  = '0;
               time_d   = 8'h00;
               div_d    = '0;
            end
         end
         S_PLAY: begin
            if (sw == target_q) begin
               hit_d    = 1'b1;
               target_d = cand;
               if (score_q < 7'd99) score_d = score_q + 7'd1;
            end
            if (wrap) begin
               tick_d = 1'b1;
               div_d  = '0;
               time_d = bcd_inc(time_q);
            end else begin
               div_d = div_q + 1'b1;
            end
            // The final tick wins over a coincident press.
            if (wrap && (bcd_inc(time_q) == ROUND_LIMIT)) state_d = S_OVER;
            else if (press)                              state_d = S_PAUSE;
         end
         S_PAUSE: if (press) state_d = S_PLAY;
         S_OVER:  if (press) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         target_q  <= '0;
         score_q   <= '0;
         time_q    <= 8'h00;
         div_q     <= '0;
         lfsr_q    <= 8'h01;
         hit_q     <= 1'b0;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         score_q   <= score_d;
         time_q    <= time_d;
         div_q     <= div_d;
         lfsr_q    <= lfsr_d;
         hit_q     <= hit_d;
         tick_q    <= tick_d;
         running_q <= (state_d == S_PLAY);
         over_q    <= (state_d == S_OVER);
      end
   end

   assign target    = target_q;
   assign score     = score_q;
   assign time_bcd  = time_q;
   assign state     = state_q;
   assign running   = running_q;
   assign hit       = hit_q;
   assign game_over = over_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: directed scenarios plus random play, every output
// compared each cycle against a rule-level game model.
module tb_guess_round_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pb  = 1'b1;
   logic [4:0] sw  = 5'd0;
   logic [4:0] target;
   logic [6:0] score;
   logic [7:0] time_bcd;
   logic [2:0] state;
   logic       running, hit, game_over, tick;

   guess_round_ctrl #(
      .TICK_DIV   (4),
      .ROUND_LIMIT(8'h59),
      .MAX_TARGET (30),
      .DEB_CYCLES (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pb       (pb),
      .sw       (sw),
      .target   (target),
      .score    (score),
      .time_bcd (time_bcd),
      .state    (state),
      .running  (running),
      .hit      (hit),
      .game_over(game_over),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Game model: 0=IDLE 1=PLAY 2=PAUSE 3=OVER, time kept as seconds 0..59.
   int         m_state, m_target, m_score, m_time, m_div;
   bit         m_hit, m_tick;
   logic [7:0] m_lfsr;
   bit         pb_ago1, pb_ago2, pb_ago3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_target = 0; m_score = 0; m_time = 0; m_div = 0;
      m_hit = 0; m_tick = 0; m_lfsr = 8'h01;
      pb_ago1 = 1; pb_ago2 = 1; pb_ago3 = 1;
   endtask

   // One clock edge of game rules; a press lands on the third edge after pb is seen low.
   task automatic model_edge(input logic pb_v, input logic [4:0] sw_v);
      bit press;
      int cand;
      int nstate;
      press   = pb_ago3 && !pb_ago2;
      pb_ago3 = pb_ago2; pb_ago2 = pb_ago1; pb_ago1 = pb_v;
      cand = (int'(m_lfsr) % 30) + 1;
      if (cand == m_target) cand = (m_target % 30) + 1;
      m_hit = 0; m_tick = 0; nstate = m_state;
      case (m_state)
         0: if (press) begin
               nstate = 1; m_target = cand; m_score = 0; m_time = 0; m_div = 0;
            end
         1: begin
               if (int'(sw_v) == m_target) begin
                  m_hit = 1; m_target = cand;
                  if (m_score < 99) m_score++;
               end
               if (m_div == 3) begin
                  m_tick = 1; m_div = 0; m_time++;
               end else m_div++;
               if (m_tick && m_time == 59) nstate = 3;
               else if (press)             nstate = 2;
            end
         2: if (press) nstate = 1;
         3: if (press) nstate = 0;
         default: nstate = 0;
      endcase
      m_state = nstate;
      m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   endtask

   task automatic check_all(input string tag);
      logic [7:0] exp_bcd;
      exp_bcd = {4'(m_time / 10), 4'(m_time % 10)};
      chk({tag, ".state"},     32'(state),     32'(m_state));
      chk({tag, ".target"},    32'(target),    32'(m_target));
      chk({tag, ".score"},     32'(score),     32'(m_score));
      chk({tag, ".time_bcd"},  32'(time_bcd),  32'(exp_bcd));
      chk({tag, ".running"},   32'(running),   32'(m_state == 1));
      chk({tag, ".game_over"}, 32'(game_over), 32'(m_state == 3));
      chk({tag, ".hit"},       32'(hit),       32'(m_hit));
      chk({tag, ".tick"},      32'(tick),      32'(m_tick));
   endtask

   task automatic cyc(input string tag, input logic pb_v, input logic [4:0] sw_v);
      pb = pb_v; sw = sw_v;
      @(posedge clk);
      model_edge(pb_v, sw_v);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pb = 1'b1; sw = 5'd0;
      #1;
      model_reset();
      check_all("reset_async");
      @(negedge clk);
      rst = 1'b0;
      check_all("reset_held");
   endtask

   task automatic press_btn(input string tag);
      for (int i = 0; i < 4; i++) cyc(tag, 1'b0, 5'd0);
      for (int i = 0; i < 4; i++) cyc(tag, 1'b1, 5'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int old_t;
      int held;
      bit reached;
      bit pb_lvl;
      logic [4:0] sw_r;

      // Reset and first press
      model_reset();
      do_reset();
      for (int i = 0; i < 3; i++) cyc("idle", 1'b1, 5'(i + 7));
      press_btn("start");
      chk("start.range", 32'(target >= 5'd1 && target <= 5'd30), 32'd1);
      chk("start.state_play", 32'(state), 32'd1);

      // Single hit
      old_t = m_target;
      cyc("hit1", 1'b1, 5'(m_target));
      chk("hit1.pulse", 32'(hit), 32'd1);
      chk("hit1.new_target_differs", 32'(int'(target) != old_t), 32'd1);
      cyc("hit1_after", 1'b1, 5'd0);
      chk("hit1.pulse_gone", 32'(hit), 32'd0);

      // Random play
      pb_lvl = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) pb_lvl = ~pb_lvl;
         if ($urandom_range(0, 3) == 0) sw_r = 5'(m_target);
         else                           sw_r = 5'($urandom_range(0, 31));
         cyc("random", pb_lvl, sw_r);
      end

      // Full round to timeout, then OVER behaviour
      do_reset();
      press_btn("round");
      reached = 0;
      for (int i = 0; i < 400 && !reached; i++) begin
         cyc("round", 1'b1, 5'd0);
         if (m_state == 3) reached = 1;
      end
      chk("round.reached_over", 32'(reached), 32'd1);
      chk("round.time_limit", 32'(time_bcd), 32'h59);
      chk("round.game_over", 32'(game_over), 32'd1);
      held = m_score;
      for (int i = 0; i < 5; i++) cyc("over_match", 1'b1, 5'(m_target));
      chk("over.score_held", 32'(score), 32'(held));
      press_btn("over_exit");
      chk("over.back_idle", 32'(state), 32'd0);

      // Pause freezes timer and divider
      press_btn("pause_start");
      for (int i = 0; i < 9; i++) cyc("pause_run", 1'b1, 5'd0);
      for (int i = 0; i < 4; i++) cyc("pause_in", 1'b0, 5'd0);
      held = m_time;
      for (int i = 0; i < 40; i++) cyc("pause_hold", 1'b1, 5'(m_target));
      chk("pause.state", 32'(state), 32'd2);
      chk("pause.time_frozen", 32'(m_time), 32'(held));
      for (int i = 0; i < 4; i++) cyc("pause_out", 1'b0, 5'd0);
      for (int i = 0; i < 12; i++) cyc("resume", 1'b1, 5'd0);
      chk("resume.state", 32'(state), 32'd1);

      // Score saturation
      do_reset();
      press_btn("sat");
      for (int i = 0; i < 100; i++) cyc("sat", 1'b1, 5'(m_target));
      chk("sat.score99", 32'(score), 32'd99);
      chk("sat.hit_still", 32'(hit), 32'd1);

      // Reset mid-round
      do_reset();
      press_btn("mid");
      for (int i = 0; i < 5; i++) cyc("mid_hits", 1'b1, 5'(m_target));
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         cyc("mid_run", 1'b1, 5'd0);
         if (m_time == 23) reached = 1;
      end
      chk("mid.reached_23", 32'(reached), 32'd1);
      chk("mid.time23", 32'(time_bcd), 32'h23);
      chk("mid.score5", 32'(score), 32'd5);
      do_reset();
      chk("mid.reset_state", 32'(state), 32'd0);
      for (int i = 0; i < 6; i++) cyc("post_reset", 1'b1, 5'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
